// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction fetch front end. Keeps the PC, issues one
//             instruction-bus read at a time, and parks the returned word
//             in a single output register for the instruction buffer.
//             Handles flush / branch redirects at any point of a bus
//             transaction, dropping data that belongs to a stale PC.
//  Revision : 1.0  initial release
//
//  Ports
//    clk, rst          : clock, synchronous active-high reset
//    stall[3:0]        : pipeline stall vector (only stall[0] is used)
//    flush, epc        : exception/ERET redirect and its target
//    branch_flag,
//    branch_target     : taken-branch redirect from ID and its target
//    inst_req,
//    inst_addr         : bus request and address (address = PC)
//    inst_addr_ok      : request accepted this cycle
//    inst_data_ok,
//    inst_rdata        : read data return
//    fetch_valid,
//    fetch_pc,
//    fetch_inst        : output register towards the instruction buffer
//    fetch_adel        : held entry is a fetch address error
//
//  Configuration
//    FETCH_ADEL_CHECK_EN : when defined, a misaligned PC raises an address
//                          error entry instead of a bus request, then the
//                          block halts until a flush. When undefined the
//                          check is absent and fetch_adel stays 0.
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  stall,
    input  logic        flush,
    input  logic [31:0] epc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst,
    output logic        fetch_adel
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_inst_q, fetch_inst_d;
    logic        fetch_adel_q, fetch_adel_d;
    logic        halt_q, halt_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        occupied;
    logic        misaligned;
    logic        addr_acc;
    logic        unused_stall;

    assign unused_stall = ^stall[3:1];

    // flush outranks branch
    assign redirect    = flush | branch_flag;
    assign redirect_pc = flush ? epc : branch_target;

    // The held entry will still be there after the next edge, so nothing
    // may be written into the output register this cycle.
    assign occupied = fetch_valid_q & stall[0];

`ifdef FETCH_ADEL_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign inst_req  = (state_q == S_REQ) & ~misaligned & ~rst;
    assign inst_addr = pc_q;
    assign addr_acc  = inst_req & inst_addr_ok;

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_inst  = fetch_inst_q;
    assign fetch_adel  = fetch_adel_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        // entry is consumed whenever the instruction buffer is not stalled
        fetch_valid_d = stall[0] ? fetch_valid_q : 1'b0;
        fetch_adel_d  = stall[0] ? fetch_adel_q  : 1'b0;
        fetch_pc_d    = fetch_pc_q;
        fetch_inst_d  = fetch_inst_q;
        halt_d        = halt_q;

        if (redirect) begin
            pc_d          = redirect_pc;
            fetch_valid_d = 1'b0;
            fetch_adel_d  = 1'b0;
            if (flush) begin
                halt_d = 1'b0;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    // after an address error only a flush restarts fetching
                    state_d = (halt_q && !flush) ? S_IDLE : S_REQ;
                end else if (halt_q) begin
                    state_d = S_IDLE;
                end else if (misaligned) begin
                    if (!occupied) begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        fetch_inst_d  = 32'h0;
                        fetch_adel_d  = 1'b1;
                        halt_d        = 1'b1;
                    end
                end else if (!fetch_valid_q || !stall[0]) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (redirect) begin
                    // an accepted request still returns data for the old PC
                    state_d = addr_acc ? S_DISCARD : S_REQ;
                end else if (misaligned) begin
                    if (!occupied) begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        fetch_inst_d  = 32'h0;
                        fetch_adel_d  = 1'b1;
                        halt_d        = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (addr_acc) begin
                    state_d = S_WAIT;
                end else if (occupied) begin
                    // stop requesting while the held entry cannot drain
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    state_d = inst_data_ok ? S_REQ : S_DISCARD;
                end else if (inst_data_ok) begin
                    if (occupied) begin
                        // Nowhere to put the word: drop it and keep the PC so
                        // the same address is fetched again once the entry drains.
                        state_d = S_IDLE;
                    end else begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = pc_q;
                        fetch_inst_d  = inst_rdata;
                        fetch_adel_d  = 1'b0;
                        pc_d          = pc_q + 32'd4;
                        state_d       = stall[0] ? S_IDLE : S_REQ;
                    end
                end
            end

            S_DISCARD: begin
                if (inst_data_ok) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'h0;
            fetch_inst_q  <= 32'h0;
            fetch_adel_q  <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_adel_q  <= fetch_adel_d;
            halt_q        <= halt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Purpose  : Directed self-checking bench for if_fetch. Inputs change and
//             outputs are observed on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stall;
    logic        flush;
    logic [31:0] epc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_adel;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'hBFC00000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .epc           (epc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_inst    (fetch_inst),
        .fetch_adel    (fetch_adel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the DUT in REQ; returns one falling edge
    // after the data beat, with the word expected in the output register.
    task automatic fetch_one(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_req"}, 32'(inst_req), 32'd1);
        chk({tag, "_addr"}, inst_addr, a);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        chk({tag, "_wait_noreq"}, 32'(inst_req), 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = d;
        @(negedge clk);
        inst_data_ok = 1'b0;
        chk({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        chk({tag, "_pc"}, fetch_pc, a);
        chk({tag, "_inst"}, fetch_inst, d);
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 4'h0;
        flush         = 1'b0;
        epc           = 32'h0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        inst_addr_ok  = 1'b0;
        inst_data_ok  = 1'b0;
        inst_rdata    = 32'h0;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_inst", fetch_inst, 32'h0);
        chk("rst_adel", 32'(fetch_adel), 32'd0);

        // sequential fetch after reset release
        rst = 1'b0;
        @(negedge clk);
        fetch_one("seq0", 32'hBFC00000, 32'h11110000);
        fetch_one("seq1", 32'hBFC00004, 32'h11110004);

        // stall holds the entry and parks fetching
        stall = 4'h1;
        chk("stall_req_still", 32'(inst_req), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_noreq", 32'(inst_req), 32'd0);
            chk("stall_valid", 32'(fetch_valid), 32'd1);
            chk("stall_pc", fetch_pc, 32'hBFC00004);
            chk("stall_inst", fetch_inst, 32'h11110004);
            @(negedge clk);
        end
        stall = 4'h0;
        @(negedge clk);
        chk("unstall_consumed", 32'(fetch_valid), 32'd0);
        fetch_one("seq2", 32'hBFC00008, 32'h11110008);

        // flush while waiting for data: stale word dropped
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        flush        = 1'b1;
        epc          = 32'hBFC00380;
        @(negedge clk);
        flush = 1'b0;
        chk("disc_valid", 32'(fetch_valid), 32'd0);
        chk("disc_noreq", 32'(inst_req), 32'd0);
        @(negedge clk);
        chk("disc_noreq2", 32'(inst_req), 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        inst_data_ok = 1'b0;
        chk("disc_dropped", 32'(fetch_valid), 32'd0);
        fetch_one("epc", 32'hBFC00380, 32'h22220380);

        // flush outranks branch
        flush         = 1'b1;
        epc           = 32'h80000180;
        branch_flag   = 1'b1;
        branch_target = 32'h80001000;
        @(negedge clk);
        flush       = 1'b0;
        branch_flag = 1'b0;
        chk("prio_addr", inst_addr, 32'h80000180);
        chk("prio_valid", 32'(fetch_valid), 32'd0);
        chk("prio_req", 32'(inst_req), 32'd1);

        // misaligned branch target
        branch_flag   = 1'b1;
        branch_target = 32'h80000002;
        @(negedge clk);
        branch_flag = 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
        chk("adel_noreq", 32'(inst_req), 32'd0);
        @(negedge clk);
        chk("adel_valid", 32'(fetch_valid), 32'd1);
        chk("adel_flag", 32'(fetch_adel), 32'd1);
        chk("adel_pc", fetch_pc, 32'h80000002);
        chk("adel_inst", fetch_inst, 32'h0);
        @(negedge clk);
        chk("adel_halt_noreq", 32'(inst_req), 32'd0);
`else
        chk("mis_req", 32'(inst_req), 32'd1);
        chk("mis_addr", inst_addr, 32'h80000002);
        chk("mis_adel", 32'(fetch_adel), 32'd0);
`endif

        // flush back to an aligned address, then reset in WAIT
        flush = 1'b1;
        epc   = 32'hBFC00100;
        @(negedge clk);
        flush = 1'b0;
        chk("recov_req", 32'(inst_req), 32'd1);
        chk("recov_addr", inst_addr, 32'hBFC00100);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        chk("rstw_req", 32'(inst_req), 32'd0);
        chk("rstw_valid", 32'(fetch_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_restart_req", 32'(inst_req), 32'd1);
        chk("rstw_restart_addr", inst_addr, 32'hBFC00000);

        // inst_req drops in the same cycle rst rises
        rst = 1'b1;
        #1;
        chk("rst_comb_req", 32'(inst_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // redirect coinciding with data return: word dropped, go straight to REQ
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok  = 1'b0;
        inst_data_ok  = 1'b1;
        inst_rdata    = 32'hCAFEF00D;
        branch_flag   = 1'b1;
        branch_target = 32'h80001000;
        @(negedge clk);
        inst_data_ok = 1'b0;
        branch_flag  = 1'b0;
        chk("brdat_valid", 32'(fetch_valid), 32'd0);
        chk("brdat_req", 32'(inst_req), 32'd1);
        chk("brdat_addr", inst_addr, 32'h80001000);

        // 32-bit PC wrap
        branch_flag   = 1'b1;
        branch_target = 32'hFFFFFFFC;
        @(negedge clk);
        branch_flag = 1'b0;
        fetch_one("wrap", 32'hFFFFFFFC, 32'h3333FFFC);
        chk("wrap_addr", inst_addr, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
